// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch queue     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int                       FETCH_ENTRY_W = 64;
  localparam logic [31:0]              NOP_INSTR     = 32'h0000_0013;
  localparam logic [FETCH_ENTRY_W-1:0] NOP_ENTRY     = {NOP_INSTR, 32'h0000_0000};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_lane_count.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue_lane_count : leading-ones count of wr_valid from lane 0        |
// | Revision               : 1.0                                               |
// +----------------------------------------------------------------------------+
module fetch_queue_lane_count #(
  parameter  int LANES = 2,
  localparam int N_W   = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] wr_valid,
  output logic [N_W-1:0]   n_wr
);

  logic run;

  always_comb begin
    n_wr = '0;
    run  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      run = run & wr_valid[i];
      if (run) n_wr = n_wr + N_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : multi-lane show-ahead instruction queue, fetch -> decode     |
// | Option      : FETCH_QUEUE_BYPASS_EN enables empty-queue write->read bypass |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int ENTRY_W  = FETCH_ENTRY_W,
  parameter  int DEPTH    = 32,
  parameter  int WR_LANES = 2,
  parameter  int RD_LANES = 2,
  localparam int CNT_W    = $clog2(DEPTH) + 1,
  localparam int POP_W    = $clog2(RD_LANES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WR_LANES-1:0]          wr_valid,
  input  logic [WR_LANES*ENTRY_W-1:0]  wr_data,
  output logic                         wr_ready,
  output logic [RD_LANES-1:0]          rd_valid,
  output logic [RD_LANES*ENTRY_W-1:0]  rd_data,
  input  logic [POP_W-1:0]             rd_pop,
  output logic [CNT_W-1:0]             count,
  output logic                         empty,
  output logic                         full
);

  localparam int                 PTR_W = $clog2(DEPTH);
  localparam int                 WRN_W = $clog2(WR_LANES + 1);
  localparam logic [ENTRY_W-1:0] NOP   = ENTRY_W'(NOP_ENTRY);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic [WRN_W-1:0]   n_wr;
  logic [WRN_W-1:0]   n_wr_acc;
  logic [POP_W-1:0]   n_valid;
  logic [POP_W-1:0]   n_pop;
  logic               wr_accept;

  fetch_queue_lane_count #(
    .LANES (WR_LANES)
  ) u_lane_count (
    .wr_valid (wr_valid),
    .n_wr     (n_wr)
  );

  assign wr_ready  = (count_q <= CNT_W'(DEPTH - WR_LANES));
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign wr_accept = wr_ready && !flush && !rst;
  assign n_wr_acc  = wr_accept ? n_wr : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_active;
  assign bypass_active = empty && !flush && !rst;
`endif

  for (genvar k = 0; k < RD_LANES; k++) begin : g_rd_lane
    logic [ENTRY_W-1:0] stored;
    logic [ENTRY_W-1:0] src;
    logic               vld;

    assign stored = mem_q[rd_ptr_q + PTR_W'(k)];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (k < WR_LANES) begin : g_bypass
      assign vld = bypass_active ? (n_wr > WRN_W'(k)) : (count_q > CNT_W'(k));
      assign src = bypass_active ? wr_data[k*ENTRY_W +: ENTRY_W] : stored;
    end else begin : g_no_bypass
      assign vld = count_q > CNT_W'(k);
      assign src = stored;
    end
`else
    assign vld = count_q > CNT_W'(k);
    assign src = stored;
`endif
    assign rd_valid[k]                   = vld;
    assign rd_data[k*ENTRY_W +: ENTRY_W] = vld ? src : NOP;
  end

  // Valid lanes are always contiguous from lane 0, so a popcount gives the clamp limit.
  always_comb begin
    n_valid = '0;
    for (int k = 0; k < RD_LANES; k++) begin
      if (rd_valid[k]) n_valid = n_valid + POP_W'(1);
    end
    n_pop = (rd_pop > n_valid) ? n_valid : rd_pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(n_wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    count_d  = count_q + CNT_W'(n_wr_acc) - CNT_W'(n_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bypassed-and-popped entries land behind rd_ptr and are never read back.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_LANES; i++) begin
      if (wr_accept && (n_wr > WRN_W'(i))) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= wr_data[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue : directed + random scoreboard bench for fetch_queue        |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 32;
  localparam int WR    = 2;
  localparam int RD    = 2;
  localparam int EW    = 64;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [WR-1:0]   wr_valid;
  logic [WR*EW-1:0] wr_data;
  logic            wr_ready;
  logic [RD-1:0]   rd_valid;
  logic [RD*EW-1:0] rd_data;
  logic [1:0]      rd_pop;
  logic [5:0]      count;
  logic            empty;
  logic            full;

  int              tests = 0;
  int              fails = 0;
  int unsigned     seq   = 0;
  logic [EW-1:0]   sb[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .ENTRY_W  (EW),
    .DEPTH    (DEPTH),
    .WR_LANES (WR),
    .RD_LANES (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_pop   (rd_pop),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, compare against the scoreboard, then advance the model.
  task automatic step(input logic [1:0] wv, input int pop, input logic fl);
    logic [EW-1:0] e   [2];
    logic [EW-1:0] vis [2];
    logic [1:0]    ev;
    fetch_entry_t  fe;
    int            n_wr, acc, n_vis, n_pop;

    for (int i = 0; i < 2; i++) begin
      fe.instr = 32'hA000_0000 | seq;
      fe.pc    = seq * 4;
      e[i]     = fe;
      seq++;
    end
    wr_valid = wv;
    wr_data  = {e[1], e[0]};
    rd_pop   = 2'(pop);
    flush    = fl;

    n_wr  = wv[0] ? (wv[1] ? 2 : 1) : 0;
    acc   = (sb.size() <= DEPTH - WR) ? n_wr : 0;
    vis[0] = NOP_ENTRY;
    vis[1] = NOP_ENTRY;
    ev    = 2'b00;
    n_vis = 0;
    if (BYP && sb.size() == 0 && !fl) begin
      for (int i = 0; i < n_wr; i++) begin
        vis[i] = e[i];
        ev[i]  = 1'b1;
      end
      n_vis = n_wr;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i < sb.size()) begin
          vis[i] = sb[i];
          ev[i]  = 1'b1;
          n_vis++;
        end
      end
    end
    n_pop = (pop > n_vis) ? n_vis : pop;

    @(negedge clk);
    check("count",    count,    sb.size());
    check("wr_ready", wr_ready, sb.size() <= DEPTH - WR);
    check("empty",    empty,    sb.size() == 0);
    check("full",     full,     sb.size() == DEPTH);
    check("rd_valid", rd_valid, ev);
    check("lane0",    rd_data[0*EW +: EW], vis[0]);
    check("lane1",    rd_data[1*EW +: EW], vis[1]);

    if (fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < acc; i++) sb.push_back(e[i]);
      repeat (n_pop) void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    wr_valid = '0;
    wr_data  = '0;
    rd_pop   = '0;
    repeat (2) begin
      wr_valid = 2'($urandom);
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      rd_pop   = 2'($urandom_range(0, 2));
      flush    = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    flush    = 1'b0;
    wr_valid = '0;
    rd_pop   = '0;
    sb.delete();

    // Reset state, then fill to full and attempt an overflow write
    step(2'b00, 0, 1'b0);
    repeat (15) step(2'b11, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    step(2'b00, 0, 1'b0);
    repeat (16) step(2'b00, 2, 1'b0);

    // Move pointers to 30, then write across the wrap point and read it back
    repeat (15) step(2'b11, 0, 1'b0);
    repeat (15) step(2'b00, 2, 1'b0);
    repeat (4)  step(2'b11, 0, 1'b0);
    step(2'b00, 1, 1'b0);
    repeat (4)  step(2'b00, 2, 1'b0);

    // Simultaneous write/pop, non-contiguous valid, over-pop clamp
    step(2'b11, 0, 1'b0);
    step(2'b10, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    step(2'b01, 0, 1'b0);
    step(2'b11, 1, 1'b0);
    step(2'b01, 2, 1'b0);
    step(2'b00, 2, 1'b0);
    step(2'b00, 2, 1'b0);
    step(2'b00, 2, 1'b0);
    step(2'b00, 0, 1'b0);

    // Flush with concurrent write and pop
    repeat (10) step(2'b11, 0, 1'b0);
    step(2'b11, 2, 1'b1);
    step(2'b00, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    step(2'b00, 2, 1'b0);

    // Write into an empty queue with a same-cycle pop of one lane
    step(2'b11, 1, 1'b0);
    step(2'b00, 0, 1'b0);
    step(2'b00, 2, 1'b0);
    step(2'b00, 0, 1'b0);

    // Mixed random traffic
    for (int n = 0; n < 80; n++) begin
      step(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 19) == 0);
    end
    step(2'b00, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
